hazard_stall_ctrl: RTL

// - Pipeline sequencer between the decode-stage control decoder and the 5-stage pipeline registers.
// - Tracks EX/MEM destination regs internally, detects load-use and JR hazards, flushes on taken branch/jump.
// - Freezes the whole pipeline during data-memory wait.
// - Drives PC, IF/ID and ID/EX enables and bubble insertion.

---
 rtl/hazard_stall_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: load-use / JR stall detection, branch and jump flush, and memory-wait freeze.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
  parameter int RA_W = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic [RA_W-1:0] id_dest,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [1:0]      id_jump,
  input  logic            id_j_jump,
  input  logic            ex_br_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            jr_fwd,
  output logic [2:0]      state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    JR_STALL   = 3'd2,
    MEM_WAIT   = 3'd3,
    FLUSH      = 3'd4
  } state_e;

  localparam logic [RA_W-1:0] REG_ZERO = {RA_W{1'b0}};

  state_e          state_r;
  state_e          ret_state_r;
  state_e          next_state_s;
  state_e          next_ret_s;
  state_e          eff_state_s;

  logic [RA_W-1:0] ex_rd_r;
  logic            ex_reg_write_r;
  logic            ex_mem_read_r;
  logic [RA_W-1:0] mem_rd_r;
  logic            mem_reg_write_r;
  logic            mem_mem_read_r;

  logic            is_jr_s;
  logic            rs_ex_s;
  logic            rt_ex_s;
  logic            rs_mem_s;
  logic            load_use_s;
  logic            jr_hazard_s;
  logic            mem_stall_s;
  logic            freeze_s;
  logic            hz_stall_s;

  // A source register depends on a stage when it is written there; register 0 never matches.
  function automatic logic reg_match(input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] rd,
                                     input logic            wr);
    reg_match = (src != REG_ZERO) && (src == rd) && wr;
  endfunction

  // Hazard terms against the EX and MEM shadow stages
  always_comb begin
    is_jr_s     = id_valid && ((id_jump == 2'b01) || (id_jump == 2'b10));
    rs_ex_s     = reg_match(id_rs, ex_rd_r, ex_reg_write_r);
    rt_ex_s     = id_uses_rt && reg_match(id_rt, ex_rd_r, ex_reg_write_r);
    rs_mem_s    = reg_match(id_rs, mem_rd_r, mem_reg_write_r);
    load_use_s  = id_valid && ex_mem_read_r && (rs_ex_s || rt_ex_s);
    // JR reads rs in ID, so a producer in EX or a load still in MEM must drain first
    jr_hazard_s = is_jr_s && (rs_ex_s || (rs_mem_s && mem_mem_read_r));
    mem_stall_s = mem_req && !mem_ready;
    if (state_r == MEM_WAIT) begin
      eff_state_s = ret_state_r;
    end else begin
      eff_state_s = state_r;
    end
  end

  // Next-state and pipeline-control decode
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    jr_fwd       = 1'b0;
    freeze_s     = 1'b0;
    hz_stall_s   = 1'b0;
    next_state_s = RUN;
    next_ret_s   = ret_state_r;
    if (!rst_n) begin
      next_state_s = RUN;
    end else if (mem_stall_s) begin
      // Whole pipeline frozen; a pending taken branch is replayed as FLUSH on release
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      freeze_s     = 1'b1;
      next_state_s = MEM_WAIT;
      if (state_r == MEM_WAIT) begin
        next_ret_s = ret_state_r;
      end else if (ex_br_taken) begin
        next_ret_s = FLUSH;
      end else begin
        next_ret_s = state_r;
      end
    end else begin
      case (eff_state_s)
        RUN, LOAD_STALL, JR_STALL, FLUSH: begin
          if (ex_br_taken || (eff_state_s == FLUSH)) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            next_state_s = RUN;
          end else if (load_use_s) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            hz_stall_s   = 1'b1;
            next_state_s = LOAD_STALL;
          end else if (jr_hazard_s) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            hz_stall_s   = 1'b1;
            next_state_s = JR_STALL;
          end else if (id_valid && (id_j_jump || is_jr_s)) begin
            ifid_flush   = 1'b1;
            jr_fwd       = is_jr_s && rs_mem_s && !mem_mem_read_r;
            next_state_s = RUN;
          end else begin
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = RUN;
        end
      endcase
    end
  end

  // FSM state and saved return state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      ret_state_r <= RUN;
    end else begin
      state_r     <= next_state_s;
      ret_state_r <= next_ret_s;
    end
  end

  // Shadow copy of the EX/MEM destination fields; holds while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_r         <= REG_ZERO;
      ex_reg_write_r  <= 1'b0;
      ex_mem_read_r   <= 1'b0;
      mem_rd_r        <= REG_ZERO;
      mem_reg_write_r <= 1'b0;
      mem_mem_read_r  <= 1'b0;
    end else if (!freeze_s) begin
      if (idex_bubble || !id_valid) begin
        ex_rd_r        <= REG_ZERO;
        ex_reg_write_r <= 1'b0;
        ex_mem_read_r  <= 1'b0;
      end else begin
        ex_rd_r        <= id_dest;
        ex_reg_write_r <= id_reg_write;
        ex_mem_read_r  <= id_mem_read;
      end
      mem_rd_r        <= ex_rd_r;
      mem_reg_write_r <= ex_reg_write_r;
      mem_mem_read_r  <= ex_mem_read_r;
    end
  end

  assign state = state_r;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] memwait_cnt_r;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r   <= {CNT_W{1'b0}};
      flush_cnt_r   <= {CNT_W{1'b0}};
      memwait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (hz_stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (ifid_flush && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
      if (freeze_s && (memwait_cnt_r != CNT_MAX)) begin
        memwait_cnt_r <= memwait_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;
  assign memwait_cnt = memwait_cnt_r;
`endif

endmodule
